io_link_ctrl: RTL and testbench

//  Sequences the UART serial link feeding the AGC IO register file. RX side parses framed bytes

---
 rtl/io_link_pkg.sv | 31 +++
 rtl/io_link_rr_pick.sv | 26 ++
 rtl/io_link_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_io_link_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_link_pkg.sv
// Shared constants and state types for the AGC UART link controller.
package io_link_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         N_IN_CH   = 6;

    typedef enum logic [2:0] {
        CH_VERB   = 3'd0,
        CH_NOUN   = 3'd1,
        CH_AXI_G  = 3'd2,
        CH_AXI_RA = 3'd3,
        CH_AXI_RB = 3'd4,
        CH_AXI_ATX = 3'd5
    } in_ch_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_CHAN = 2'd1,
        RX_HI   = 2'd2,
        RX_LO   = 2'd3
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_SYNC = 3'd1,
        TX_CHAN = 3'd2,
        TX_HI   = 3'd3,
        TX_LO   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/io_link_rr_pick.sv
// Combinational round-robin picker: first set bit of pending at or after ptr.
module io_link_rr_pick
    import io_link_pkg::*;
#(
    parameter int N  = 8,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  pending,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);

    // Scan offsets from the farthest down to zero so the closest pending channel wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending[(int'(ptr) + i) % N]) begin
                grant = PW'((int'(ptr) + i) % N);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_link_ctrl.sv
// UART link sequencer between uart_rx/uart_tx and the AGC IO register file.
//
// RX FSM
//   state   | meaning
//   RX_IDLE | hunting for SYNC, other bytes dropped
//   RX_CHAN | expecting channel byte (0..5)
//   RX_HI   | expecting {0, d[14:8]}
//   RX_LO   | expecting d[7:0], commit frame
//
// TX FSM
//   state   | meaning
//   TX_IDLE | pick next pending output channel, snapshot its data
//   TX_SYNC | send SYNC byte
//   TX_CHAN | send absolute channel select
//   TX_HI   | send {0, d[14:8]}
//   TX_LO   | send d[7:0]
module io_link_ctrl
    import io_link_pkg::*;
#(
    parameter int N_OUT_CH   = 8,
    parameter int OUT_BASE   = 8,
    parameter int RX_TIMEOUT = 50000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                IO_write_en,
    input  logic [4:0]          IO_write_sel,
    input  logic [14:0]         IO_write_data,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic [14:0]         DSKY_VERB_data,
    output logic [14:0]         DSKY_NOUN_data,
    output logic [14:0]         AXI_G_data,
    output logic [14:0]         AXI_RA_data,
    output logic [14:0]         AXI_RB_data,
    output logic [14:0]         AXI_ATX_data,
    output logic [5:0]          chan_updated,
    output logic                rx_frame_err,
    output logic [N_OUT_CH-1:0] tx_pending
);

    localparam int PW = (N_OUT_CH > 1) ? $clog2(N_OUT_CH) : 1;
    localparam int CW = $clog2(RX_TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(RX_TIMEOUT);

    // ---------------- RX side ----------------
    rx_state_t     rx_state, rx_state_nxt;
    logic [2:0]    rx_chan;
    logic [6:0]    rx_hi;
    logic [CW-1:0] to_cnt;
    logic [14:0]   ch_reg [N_IN_CH];
    logic          rx_timeout;
    logic          chan_ld, hi_ld, commit, err_nxt;

    // RX next-state: byte parsing, frame checks and inter-byte timeout.
    always_comb begin
        rx_state_nxt = rx_state;
        chan_ld      = 1'b0;
        hi_ld        = 1'b0;
        commit       = 1'b0;
        err_nxt      = 1'b0;
        rx_timeout   = (rx_state != RX_IDLE) && !rx_valid && (to_cnt == TO_VAL);
        if (rx_timeout) begin
            err_nxt      = 1'b1;
            rx_state_nxt = RX_IDLE;
        end else if (rx_valid) begin
            case (rx_state)
                RX_IDLE: begin
                    if (rx_data == SYNC_BYTE) rx_state_nxt = RX_CHAN;
                end
                RX_CHAN: begin
                    if (rx_data > 8'(N_IN_CH - 1)) begin
                        err_nxt      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        chan_ld      = 1'b1;
                        rx_state_nxt = RX_HI;
                    end
                end
                RX_HI: begin
                    if (rx_data[7]) begin
                        err_nxt      = 1'b1;
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        hi_ld        = 1'b1;
                        rx_state_nxt = RX_LO;
                    end
                end
                RX_LO: begin
                    commit       = 1'b1;
                    rx_state_nxt = RX_IDLE;
                end
                default: rx_state_nxt = RX_IDLE;
            endcase
        end
    end

    // RX state, frame holding registers and the timeout counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_chan  <= '0;
            rx_hi    <= '0;
            to_cnt   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            if (chan_ld) rx_chan <= rx_data[2:0];
            if (hi_ld)   rx_hi   <= rx_data[6:0];
            if (rx_valid || rx_state == RX_IDLE) to_cnt <= '0;
            else if (to_cnt != TO_VAL)           to_cnt <= to_cnt + 1'b1;
        end
    end

    // Channel registers load all 15 bits at once, only on a complete frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_IN_CH; i++) ch_reg[i] <= '0;
            chan_updated <= '0;
            rx_frame_err <= 1'b0;
        end else begin
            chan_updated <= '0;
            rx_frame_err <= err_nxt;
            if (commit) begin
                ch_reg[rx_chan] <= {rx_hi, rx_data};
                chan_updated    <= 6'(1) << rx_chan;
            end
        end
    end

    assign DSKY_VERB_data = ch_reg[int'(CH_VERB)];
    assign DSKY_NOUN_data = ch_reg[int'(CH_NOUN)];
    assign AXI_G_data     = ch_reg[int'(CH_AXI_G)];
    assign AXI_RA_data    = ch_reg[int'(CH_AXI_RA)];
    assign AXI_RB_data    = ch_reg[int'(CH_AXI_RB)];
    assign AXI_ATX_data   = ch_reg[int'(CH_AXI_ATX)];

    // ---------------- TX side ----------------
    tx_state_t          tx_state, tx_state_nxt;
    logic [14:0]        shadow [N_OUT_CH];
    logic [N_OUT_CH-1:0] pending, set_mask, clr_mask;
    logic [PW-1:0]      rr_ptr, gnt, wr_idx, snap_idx;
    logic               gnt_valid, wr_hit, pick, byte_ok;
    logic [14:0]        snap_data;
    logic [7:0]         tx_data_nxt, tx_chan_byte;
    logic               tx_start_nxt;
    int                 sel_off;

    io_link_rr_pick #(.N(N_OUT_CH), .PW(PW)) u_rr_pick (
        .pending (pending),
        .ptr     (rr_ptr),
        .grant   (gnt),
        .valid   (gnt_valid)
    );

    // CPU write decode; a set in the same cycle as the snapshot clear keeps the bit pending.
    always_comb begin
        sel_off  = int'(IO_write_sel) - OUT_BASE;
        wr_hit   = IO_write_en && (sel_off >= 0) && (sel_off < N_OUT_CH);
        wr_idx   = PW'(sel_off);
        set_mask = '0;
        clr_mask = '0;
        if (wr_hit) set_mask[wr_idx] = 1'b1;
        if (pick)   clr_mask[gnt]    = 1'b1;
    end

    // Shadow copies of output channels plus their pending flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OUT_CH; i++) shadow[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_hit) shadow[wr_idx] <= IO_write_data;
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    assign byte_ok      = !tx_start && !tx_busy;
    assign tx_chan_byte = 8'(OUT_BASE + int'(snap_idx));

    // TX next-state: one byte per state, the cycle after tx_start is never a busy test.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        pick         = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (gnt_valid) begin
                    pick         = 1'b1;
                    tx_state_nxt = TX_SYNC;
                end
            end
            TX_SYNC: begin
                if (byte_ok) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = SYNC_BYTE;
                    tx_state_nxt = TX_CHAN;
                end
            end
            TX_CHAN: begin
                if (byte_ok) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = tx_chan_byte;
                    tx_state_nxt = TX_HI;
                end
            end
            TX_HI: begin
                if (byte_ok) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = {1'b0, snap_data[14:8]};
                    tx_state_nxt = TX_LO;
                end
            end
            TX_LO: begin
                if (byte_ok) begin
                    tx_start_nxt = 1'b1;
                    tx_data_nxt  = snap_data[7:0];
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // TX state, byte outputs, snapshot of the winning channel and the RR pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_state  <= TX_IDLE;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            snap_data <= '0;
            snap_idx  <= '0;
            rr_ptr    <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            if (pick) begin
                snap_data <= shadow[gnt];
                snap_idx  <= gnt;
                rr_ptr    <= (gnt == PW'(N_OUT_CH - 1)) ? '0 : gnt + 1'b1;
            end
        end
    end

    assign tx_pending = pending;

endmodule

// File: tb/tb_io_link_ctrl.sv
// Scoreboard bench for io_link_ctrl: RX frames and TX rounds against a frame-level model.
module tb_io_link_ctrl;

    localparam int N_OUT  = 8;
    localparam int BASE   = 8;
    localparam int TO     = 40;

    logic        clock, reset_n;
    logic        IO_write_en;
    logic [4:0]  IO_write_sel;
    logic [14:0] IO_write_data;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [14:0] DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data, AXI_RA_data, AXI_RB_data, AXI_ATX_data;
    logic [5:0]  chan_updated;
    logic        rx_frame_err;
    logic [N_OUT-1:0] tx_pending;

    io_link_ctrl #(.N_OUT_CH(N_OUT), .OUT_BASE(BASE), .RX_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .IO_write_en(IO_write_en), .IO_write_sel(IO_write_sel), .IO_write_data(IO_write_data),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .DSKY_VERB_data(DSKY_VERB_data), .DSKY_NOUN_data(DSKY_NOUN_data),
        .AXI_G_data(AXI_G_data), .AXI_RA_data(AXI_RA_data), .AXI_RB_data(AXI_RB_data),
        .AXI_ATX_data(AXI_ATX_data),
        .chan_updated(chan_updated), .rx_frame_err(rx_frame_err), .tx_pending(tx_pending)
    );

    typedef struct { bit err; int ch; logic [14:0] data; } rx_item_t;
    typedef struct { int ch; logic [14:0] data; } tx_item_t;

    rx_item_t rxq[$];
    tx_item_t txq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int n_tx_start = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] frame_word(input int ch, input logic [14:0] d);
        return {8'hA5, 8'(BASE + ch), 1'b0, d[14:8], d[7:0]};
    endfunction

    // UART transmitter model: busy rises the cycle after tx_start for a random byte time.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clock);
            if (reset_n && tx_start) begin
                @(posedge clock);
                #1 tx_busy = 1'b1;
                repeat ($urandom_range(8, 16)) @(posedge clock);
                #1 tx_busy = 1'b0;
            end
        end
    end

    // Monitor: rebuilds TX frames and RX events and pops the scoreboard.
    initial begin
        logic [7:0]  tb_bytes [4];
        int          nb;
        logic [14:0] exp_ch [6];
        tx_item_t    te;
        rx_item_t    re;
        nb = 0;
        for (int i = 0; i < 6; i++) exp_ch[i] = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                nb = 0;
                for (int i = 0; i < 6; i++) exp_ch[i] = '0;
            end else begin
                if (tx_start) begin
                    n_tx_start++;
                    chk("tx_start_when_busy", 96'(tx_busy), 96'(0));
                    tb_bytes[nb] = tx_data;
                    nb++;
                    if (nb == 4) begin
                        nb = 0;
                        if (txq.size() == 0) begin
                            chk("tx_unexpected_frame", {tb_bytes[0], tb_bytes[1], tb_bytes[2], tb_bytes[3]}, 96'(0));
                        end else begin
                            te = txq.pop_front();
                            chk("tx_frame", {tb_bytes[0], tb_bytes[1], tb_bytes[2], tb_bytes[3]},
                                96'(frame_word(te.ch, te.data)));
                        end
                    end
                end
                if (chan_updated != 6'd0 || rx_frame_err) begin
                    if (rxq.size() == 0) begin
                        chk("rx_unexpected_event", {chan_updated, rx_frame_err}, 96'(0));
                    end else begin
                        re = rxq.pop_front();
                        if (re.err) begin
                            chk("rx_err_event", {chan_updated, rx_frame_err}, {6'd0, 1'b1});
                        end else begin
                            exp_ch[re.ch] = re.data;
                            chk("rx_upd_event", {chan_updated, rx_frame_err}, {6'(1) << re.ch, 1'b0});
                        end
                        chk("rx_channels",
                            {DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data, AXI_RA_data, AXI_RB_data, AXI_ATX_data},
                            {exp_ch[0], exp_ch[1], exp_ch[2], exp_ch[3], exp_ch[4], exp_ch[5]});
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(posedge clock);
        #1 rx_data = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
        repeat (gap) @(posedge clock);
    endtask

    task automatic send_good(input int ch, input logic [14:0] d);
        rxq.push_back('{err: 1'b0, ch: ch, data: d});
        send_byte(8'hA5, $urandom_range(0, 3));
        send_byte(8'(ch), $urandom_range(0, 3));
        send_byte({1'b0, d[14:8]}, $urandom_range(0, 3));
        send_byte(d[7:0], 0);
    endtask

    task automatic cpu_write(input int sel, input logic [14:0] d);
        @(posedge clock);
        #1 IO_write_en = 1'b1;
        IO_write_sel  = 5'(sel);
        IO_write_data = d;
        @(posedge clock);
        #1 IO_write_en = 1'b0;
    endtask

    task automatic wait_sync();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(tx_start === 1'b1 && tx_data === 8'hA5) && n < 400);
        chk("tx_sync_seen", 96'(n < 400), 96'(1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((txq.size() != 0 || rxq.size() != 0) && n < 8000) begin
            @(negedge clock);
            n++;
        end
        chk("queues_drained", 96'(txq.size() + rxq.size()), 96'(0));
    endtask

    // One TX round: a lone blocker frame, then a burst of writes while it is on the wire.
    // Expected: the blocker, then every channel written in the burst once, latest data,
    // in round-robin order starting after the blocker.
    task automatic tx_round(input int b, input logic [14:0] bd, input int n,
                            input int sels [8], input logic [14:0] dat [8]);
        bit          pend [N_OUT];
        logic [14:0] sh [N_OUT];
        int          off;
        for (int i = 0; i < N_OUT; i++) begin
            pend[i] = 1'b0;
            sh[i]   = '0;
        end
        txq.push_back('{ch: b, data: bd});
        cpu_write(BASE + b, bd);
        wait_sync();
        for (int k = 0; k < n; k++) begin
            cpu_write(sels[k], dat[k]);
            off = sels[k] - BASE;
            if (off >= 0 && off < N_OUT) begin
                pend[off] = 1'b1;
                sh[off]   = dat[k];
                @(negedge clock);
                chk("tx_pending_set", 96'(tx_pending[off]), 96'(1));
            end
        end
        for (int i = 0; i < N_OUT; i++) begin
            if (pend[(b + 1 + i) % N_OUT])
                txq.push_back('{ch: (b + 1 + i) % N_OUT, data: sh[(b + 1 + i) % N_OUT]});
        end
        wait_drain();
    endtask

    initial begin
        int          sels [8];
        logic [14:0] dat [8];
        int          kind, ch, c, n, base_cnt;
        logic [14:0] d;
        logic [7:0]  g;

        reset_n = 1'b0;
        IO_write_en = 1'b0;
        IO_write_sel = '0;
        IO_write_data = '0;
        rx_data = '0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_outputs",
            {DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data, AXI_RA_data, AXI_RB_data, AXI_ATX_data},
            96'(0));
        chk("reset_ctrl", {tx_data, tx_start, chan_updated, rx_frame_err, tx_pending}, 96'(0));
        reset_n = 1'b1;
        repeat (2) @(posedge clock);

        // RX directed: AXI_G update with exact one-clock latency after LO.
        rxq.push_back('{err: 1'b0, ch: 2, data: 15'h0123});
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h01, 0); send_byte(8'h23, 0);
        @(negedge clock);
        chk("rx_latency", {chan_updated, AXI_G_data}, {6'b000100, 15'h0123});

        // RX errors: bad channel, bad HI bit7, SYNC treated as data in LO.
        rxq.push_back('{err: 1'b1, ch: 0, data: '0});
        send_byte(8'hA5, 1); send_byte(8'h07, 2);
        rxq.push_back('{err: 1'b1, ch: 0, data: '0});
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h80, 2);
        rxq.push_back('{err: 1'b0, ch: 3, data: 15'h00A5});
        send_byte(8'hA5, 0); send_byte(8'h03, 0); send_byte(8'h00, 0); send_byte(8'hA5, 2);

        // Timeout mid-frame, then a clean frame recovers.
        rxq.push_back('{err: 1'b1, ch: 0, data: '0});
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!rx_frame_err && n < TO + 20);
        chk("rx_timeout_window", 96'(n >= TO && n <= TO + 2), 96'(1));
        send_good(1, 15'h0005);
        wait_drain();

        // RX random frames.
        repeat (60) begin
            kind = $urandom_range(0, 9);
            ch   = $urandom_range(0, 5);
            d    = 15'($urandom);
            if (kind < 6) begin
                send_good(ch, d);
            end else if (kind == 6) begin
                c = $urandom_range(6, 255);
                rxq.push_back('{err: 1'b1, ch: 0, data: '0});
                send_byte(8'hA5, $urandom_range(0, 3));
                send_byte(8'(c), $urandom_range(0, 3));
            end else if (kind == 7) begin
                rxq.push_back('{err: 1'b1, ch: 0, data: '0});
                send_byte(8'hA5, $urandom_range(0, 3));
                send_byte(8'(ch), $urandom_range(0, 3));
                send_byte({1'b1, d[14:8]}, $urandom_range(0, 3));
            end else begin
                g = 8'($urandom);
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(0, 3));
            end
        end
        wait_drain();

        // TX directed: single frame on sel 9.
        tx_round(1, 15'h1ABC, 0, sels, dat);
        // Coalescing behind a frame on sel 15: 8,10,8 -> ch8=3 then ch10=2.
        sels[0] = 8;  dat[0] = 15'd1;
        sels[1] = 10; dat[1] = 15'd2;
        sels[2] = 8;  dat[2] = 15'd3;
        tx_round(7, 15'h7001, 3, sels, dat);
        // In-flight collision on sel 11.
        sels[0] = 11; dat[0] = 15'h0022;
        tx_round(3, 15'h0011, 1, sels, dat);

        // TX random rounds, including out-of-range writes.
        repeat (20) begin
            n = $urandom_range(0, 6);
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 9) < 7) sels[k] = BASE + $urandom_range(0, N_OUT - 1);
                else if ($urandom_range(0, 1) == 1) sels[k] = $urandom_range(16, 31);
                else sels[k] = $urandom_range(0, 7);
                dat[k] = 15'($urandom);
            end
            tx_round($urandom_range(0, N_OUT - 1), 15'($urandom), n, sels, dat);
        end

        // Reset in TX_CHAN and RX_HI: everything cleared, the frame is abandoned.
        cpu_write(12, 15'h2AAA);
        wait_sync();
        send_byte(8'hA5, 0); send_byte(8'h01, 0);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_outputs",
            {DSKY_VERB_data, DSKY_NOUN_data, AXI_G_data, AXI_RA_data, AXI_RB_data, AXI_ATX_data},
            96'(0));
        chk("midreset_ctrl", {tx_data, tx_start, chan_updated, rx_frame_err, tx_pending}, 96'(0));
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        base_cnt = n_tx_start;
        send_byte(8'h23, 0);
        repeat (150) @(posedge clock);
        #1;
        chk("no_tx_after_reset", 96'(n_tx_start - base_cnt), 96'(0));
        chk("no_pending_after_reset", 96'(tx_pending), 96'(0));
        send_good(5, 15'h0007);
        tx_round(5, 15'h3456, 0, sels, dat);
        wait_drain();
        repeat (20) @(posedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
